// File: rtl/even_odd_tally.sv
// Even/odd frame tally: counts even and odd samples per frame and hands a
// registered summary downstream over a valid/ready handshake.
module even_odd_tally #(
    parameter int DATA_W    = 8,
    parameter int FRAME_LEN = 16,
    parameter int CNT_W     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  even_cnt,
    output logic [CNT_W-1:0]  odd_cnt,
    output logic [CNT_W-1:0]  frame_len,
    output logic              majority_even
);

    localparam logic [0:0] ACCUM  = 1'b0;
    localparam logic [0:0] REPORT = 1'b1;
    localparam logic [CNT_W-1:0] LEN_MAX = CNT_W'(FRAME_LEN);

    logic [0:0]       state;
    logic [CNT_W-1:0] even_acc, odd_acc, smp_acc;
    logic [CNT_W-1:0] even_nxt, odd_nxt, smp_nxt;
    logic             accept, is_odd, close;
    logic             unused_data;

    function automatic logic maj_even(input logic [CNT_W-1:0] e, input logic [CNT_W-1:0] o);
        return e > o;
    endfunction

    // Only bit 0 decides parity; upper bits are intentionally ignored.
    assign unused_data = ^in_data;
    assign is_odd      = in_data[0];

    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == REPORT);
    assign accept    = in_valid & in_ready;

    assign even_nxt = even_acc + {{(CNT_W-1){1'b0}}, ~is_odd};
    assign odd_nxt  = odd_acc  + {{(CNT_W-1){1'b0}},  is_odd};
    assign smp_nxt  = smp_acc  + {{(CNT_W-1){1'b0}},  1'b1};
    assign close    = accept & ((smp_nxt == LEN_MAX) | in_last);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= ACCUM;
            even_acc      <= '0;
            odd_acc       <= '0;
            smp_acc       <= '0;
            even_cnt      <= '0;
            odd_cnt       <= '0;
            frame_len     <= '0;
            majority_even <= 1'b0;
        end else if (state == ACCUM) begin
            if (accept) begin
                even_acc <= even_nxt;
                odd_acc  <= odd_nxt;
                smp_acc  <= smp_nxt;
            end
            // Summary is loaded from the updated counts so the closing sample is included.
            if (close) begin
                even_cnt      <= even_nxt;
                odd_cnt       <= odd_nxt;
                frame_len     <= smp_nxt;
                majority_even <= maj_even(even_nxt, odd_nxt);
                state         <= REPORT;
            end
        end else begin
            if (out_ready) begin
                even_acc <= '0;
                odd_acc  <= '0;
                smp_acc  <= '0;
                state    <= ACCUM;
            end
        end
    end

    always @(posedge clk) begin
        assert (FRAME_LEN >= 1 && FRAME_LEN <= 255 &&
                64'(FRAME_LEN) <= ((64'd1 << CNT_W) - 64'd1))
        else $error("even_odd_tally: FRAME_LEN does not fit in CNT_W bits");
    end

endmodule

// File: doc/even_odd_tally.md
Name: even_odd_tally

Overview:
- Streaming consumer placed directly downstream of the even/odd classification stage.
- Accepts a stream of DATA_W-bit numbers over a valid/ready handshake and classifies each one (even = bit 0 is 0).
- Counts even and odd samples per frame, then presents a registered frame summary on a second valid/ready handshake.
- A frame closes after FRAME_LEN samples, or earlier on in_last.

Parameters:
- DATA_W, 8, width of each input number.
- FRAME_LEN, 16, maximum samples per frame; legal range 1..255.
- CNT_W, 8, width of the count outputs; must satisfy 2^CNT_W - 1 >= FRAME_LEN.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  in_data is valid this cycle.
- in_data  input  DATA_W  number to classify.
- in_last  input  1  marks the final sample of a short frame; qualified by in_valid.
- in_ready  output  1  block can accept a sample.
- out_valid  output  1  frame summary is valid.
- out_ready  input  1  downstream accepts the summary.
- even_cnt  output  CNT_W  number of even samples in the frame.
- odd_cnt  output  CNT_W  number of odd samples in the frame.
- frame_len  output  CNT_W  total samples in the frame (even_cnt + odd_cnt).
- majority_even  output  1  1 when even_cnt > odd_cnt; ties give 0.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - State goes to ACCUM; internal counters clear to 0.
  - out_valid=0; even_cnt=0, odd_cnt=0, frame_len=0, majority_even=0.
  - in_ready=1 from the first cycle after reset.
  - Reset overrides everything, including mid-frame and during REPORT. A partial frame is discarded with no summary.
- States: ACCUM, REPORT. in_ready = (state==ACCUM). out_valid = (state==REPORT). Both are registered/derived from state only, never combinationally from in_valid or out_ready.
- ACCUM, on accept (in_valid & in_ready):
  - If in_data[0]==0, increment the even counter; otherwise increment the odd counter.
  - The sample counter increments.
- Frame close: an accept where either the incremented sample count == FRAME_LEN, or in_last=1.
  - On the close cycle, even_cnt, odd_cnt, frame_len and majority_even are loaded from the updated counts, including the closing sample.
  - State moves to REPORT on the next edge.
  - Latency: out_valid rises the cycle after the accepting edge of the final sample.
- in_last asserted on the FRAME_LEN-th sample closes the frame once; there is no double report.
- in_valid=0 in ACCUM: the block holds and counters are unchanged. in_last without in_valid is ignored.
- REPORT:
  - The summary outputs stay stable until out_ready=1.
  - in_ready=0; upstream must hold its data (standard valid/ready backpressure).
  - On out_valid & out_ready, the internal counters clear and state returns to ACCUM. in_ready=1 the next cycle.
  - Summary outputs keep their last values after handshake until the next frame closes. Only out_valid drops.
- No-bubble option is not required: one dead input cycle per frame is accepted.
- Counters never wrap, because FRAME_LEN bounds them. The parameter constraint above is checked with a simulation-time assertion.
- FRAME_LEN=1: every accepted sample closes a frame.
- Arithmetic: counts are unsigned CNT_W. frame_len equals the sum of the even and odd counts, with no overflow by construction.

Test Plan:
- Reset then stream 16 samples 0..15 with in_valid=1, out_ready=1 -> out_valid pulses once, one cycle after sample 15 is accepted; even_cnt=8, odd_cnt=8, frame_len=16, majority_even=0.
- Samples 5, 8, 12 with in_last on 12 -> even_cnt=2, odd_cnt=1, frame_len=3, majority_even=1.
- Full frame of 16 odd values (e.g. 255) with out_ready=0 for 10 cycles:
  - out_valid held and outputs stable; in_ready=0 throughout.
  - odd_cnt=16, even_cnt=0.
  - After out_ready=1, in_ready returns the next cycle.
- Gaps: in_valid toggled randomly over 16 samples of value 8 -> counts ignore idle cycles; even_cnt=16, odd_cnt=0, majority_even=1.
- rst_n=0 after 7 accepted samples, then a fresh frame 1, 2 with in_last -> no summary for the aborted frame; next summary even_cnt=1, odd_cnt=1, frame_len=2.
- in_last on the 16th sample -> exactly one summary with frame_len=16; the next frame starts at count 0.
